// File: rtl/alu_packet_parser.sv
// Receive framer: decodes [opcode, rsvd, len_lo, len_hi, payload] byte packets into ALU operand beats.
// Latency 1 from the completing byte to m_valid_o; in PAYLOAD, s_axis stalls only while a beat waits on m_ready_i.
module alu_packet_parser #(
  parameter int          DATA_WIDTH_P = 8,
  parameter int          OPERAND_W_P  = 32,
  parameter logic [7:0]  OP_ECHO_P    = 8'hEC,
  parameter logic [7:0]  OP_ADD_P     = 8'hA8,
  parameter logic [7:0]  OP_MUL_P     = 8'hAD,
  parameter logic [7:0]  OP_DIV_P     = 8'hAE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH_P-1:0]  s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [7:0]               m_opcode_o,
  output logic [OPERAND_W_P-1:0]   m_operand_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic                     m_first_o,
  output logic                     m_last_o,
  output logic                     bad_opcode_o,
  output logic                     len_error_o
);

  typedef enum logic [2:0] {
    ST_OPCODE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_PAYLOAD, ST_DRAIN
  } state_t;

  state_t                          state_q, state_d;
  logic [7:0]                      hdr_op_q, hdr_op_d;
  logic [7:0]                      len_lo_q, len_lo_d;
  logic [15:0]                     cnt_q, cnt_d;
  logic [OPERAND_W_P-9:0]          acc_q, acc_d;
  logic [1:0]                      idx_q, idx_d;
  logic                            first_q, first_d;
  logic                            m_valid_q, m_valid_d;
  logic [7:0]                      m_opcode_q, m_opcode_d;
  logic [OPERAND_W_P-1:0]          m_operand_q, m_operand_d;
  logic                            m_first_q, m_first_d;
  logic                            m_last_q, m_last_d;
  logic                            bad_q, bad_d;
  logic                            len_err_q, len_err_d;

  logic [15:0] len;
  logic        is_echo, is_arith, len_bad, accept, beat_ld;
  logic [OPERAND_W_P-1:0] beat_val;

  assign len      = {s_axis_tdata, len_lo_q};
  assign is_echo  = (hdr_op_q == OP_ECHO_P);
  assign is_arith = (hdr_op_q == OP_ADD_P) || (hdr_op_q == OP_MUL_P) || (hdr_op_q == OP_DIV_P);
  // Header length includes the 4 header bytes; arith payloads need at least two whole operands.
  assign len_bad  = (len < 16'd4) || (is_arith && ((len < 16'd12) || (len[1:0] != 2'b00)));
  assign s_axis_tready = (state_q == ST_PAYLOAD) ? (!m_valid_q || m_ready_i) : 1'b1;
  assign accept   = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d     = state_q;
    hdr_op_d    = hdr_op_q;
    len_lo_d    = len_lo_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    first_d     = first_q;
    m_valid_d   = m_valid_q && !m_ready_i;
    m_opcode_d  = m_opcode_q;
    m_operand_d = m_operand_q;
    m_first_d   = m_first_q;
    m_last_d    = m_last_q;
    bad_d       = 1'b0;
    len_err_d   = 1'b0;
    beat_ld     = 1'b0;
    beat_val    = '0;

    case (state_q)
      ST_OPCODE: if (accept) begin
        hdr_op_d = s_axis_tdata;
        state_d  = ST_RSVD;
      end
      ST_RSVD: if (accept) state_d = ST_LEN_LO;
      ST_LEN_LO: if (accept) begin
        len_lo_d = s_axis_tdata;
        state_d  = ST_LEN_HI;
      end
      ST_LEN_HI: if (accept) begin
        cnt_d   = (len > 16'd4) ? (len - 16'd4) : 16'd0;
        idx_d   = 2'd0;
        first_d = 1'b1;
        if (!is_echo && !is_arith) begin
          bad_d   = 1'b1;
          state_d = (len > 16'd4) ? ST_DRAIN : ST_OPCODE;
        end else if (len_bad) begin
          len_err_d = 1'b1;
          state_d   = (len > 16'd4) ? ST_DRAIN : ST_OPCODE;
        end else if (len == 16'd4) begin
          state_d = ST_OPCODE;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: if (accept) begin
        cnt_d = cnt_q - 16'd1;
        if (is_echo) begin
          beat_ld  = 1'b1;
          beat_val = {{(OPERAND_W_P-DATA_WIDTH_P){1'b0}}, s_axis_tdata};
        end else if (idx_q == 2'd3) begin
          beat_ld  = 1'b1;
          beat_val = {s_axis_tdata, acc_q};
        end else begin
          case (idx_q)
            2'd0:    acc_d[7:0]   = s_axis_tdata;
            2'd1:    acc_d[15:8]  = s_axis_tdata;
            default: acc_d[23:16] = s_axis_tdata;
          endcase
        end
        idx_d = idx_q + 2'd1;
        if (cnt_q == 16'd1) state_d = ST_OPCODE;
      end
      ST_DRAIN: if (accept) begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = ST_OPCODE;
      end
      default: state_d = ST_OPCODE;
    endcase

    if (beat_ld) begin
      m_valid_d   = 1'b1;
      m_opcode_d  = hdr_op_q;
      m_operand_d = beat_val;
      m_first_d   = first_q;
      m_last_d    = (cnt_q == 16'd1);
      first_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_OPCODE;
      hdr_op_q    <= '0;
      len_lo_q    <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      first_q     <= 1'b0;
      m_valid_q   <= 1'b0;
      m_opcode_q  <= '0;
      m_operand_q <= '0;
      m_first_q   <= 1'b0;
      m_last_q    <= 1'b0;
      bad_q       <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_op_q    <= hdr_op_d;
      len_lo_q    <= len_lo_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
      m_valid_q   <= m_valid_d;
      m_opcode_q  <= m_opcode_d;
      m_operand_q <= m_operand_d;
      m_first_q   <= m_first_d;
      m_last_q    <= m_last_d;
      bad_q       <= bad_d;
      len_err_q   <= len_err_d;
    end
  end

  assign m_valid_o    = m_valid_q;
  assign m_opcode_o   = m_opcode_q;
  assign m_operand_o  = m_operand_q;
  assign m_first_o    = m_first_q;
  assign m_last_o     = m_last_q;
  assign bad_opcode_o = bad_q;
  assign len_error_o  = len_err_q;

endmodule
